// File: rtl/nv_ram_pkg.sv
// Shared types and helpers for the parametrised 1R1W RAM.
// Holds the init-sweep state encoding, the address-range check and the power-bus width.
package nv_ram_pkg;

    localparam int PWRBUS_W = 32;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic logic in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/nv_ram_rws_param_core.sv
// Behavioural storage array: one synchronous write port, one unregistered read port.
// Kept free of reset and muxing so tools infer block or distributed RAM cleanly.
module nv_ram_rws_param_core
    import nv_ram_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wa,
    input  logic [WIDTH-1:0] i_di,
    input  logic [AW-1:0]    i_ra,
    output logic [WIDTH-1:0] o_rq
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wa] <= i_di;
        end
    end

    // Guard keeps out-of-range lookups well defined; the parent zeroes them anyway.
    assign o_rq = in_range(32'(i_ra), DEPTH) ? r_mem[i_ra] : '0;

endmodule

// File: rtl/nv_ram_rws_param.sv
// Parametrised 1R1W RAM: read latency 1 (+1 with OUT_REG), same-cycle write bypass,
// per-read valid strobe, optional zero sweep after reset; no backpressure.
module nv_ram_rws_param
    import nv_ram_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int OUT_REG   = 0,
    parameter int BYPASS    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       ra,
    input  logic                re,
    input  logic [AW-1:0]       wa,
    input  logic                we,
    input  logic [WIDTH-1:0]    di,
    output logic [WIDTH-1:0]    dout,
    output logic                dout_vld,
    output logic                init_done,
    input  logic [PWRBUS_W-1:0] pwrbus_ram_pd
);

    state_t           r_state;
    logic [AW-1:0]    r_init_cnt;
    logic             r_init_done;
    logic             r_vld1;
    logic [WIDTH-1:0] r_dat1;

    logic             w_init_we;
    logic             w_usr_we;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_wa;
    logic [WIDTH-1:0] w_mem_di;
    logic [WIDTH-1:0] w_mem_q;
    logic             w_ra_ok;
    logic             w_byp;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rd_dat;
    logic             w_unused_pwr;

    assign w_unused_pwr = ^pwrbus_ram_pd;

    // init_done doubles as the traffic gate so INIT_ZERO=0 also waits one edge after reset.
    assign w_init_we = (r_state == ST_INIT) && !rst;
    assign w_usr_we  = r_init_done && we && in_range(32'(wa), DEPTH);
    assign w_mem_we  = w_init_we || w_usr_we;
    assign w_mem_wa  = w_init_we ? r_init_cnt : wa;
    assign w_mem_di  = w_init_we ? '0 : di;

    nv_ram_rws_param_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk  (clk),
        .i_we (w_mem_we),
        .i_wa (w_mem_wa),
        .i_di (w_mem_di),
        .i_ra (ra),
        .o_rq (w_mem_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == AW'(DEPTH - 1)) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                ST_READY: r_init_done <= 1'b1;
                default:  r_state     <= ST_READY;
            endcase
        end
    end

    assign w_ra_ok  = in_range(32'(ra), DEPTH);
    assign w_byp    = (BYPASS != 0) && we && (wa == ra);
    assign w_rd_acc = r_init_done && re;
    assign w_rd_dat = !w_ra_ok ? '0 : (w_byp ? di : w_mem_q);

    // Data is captured, not the address, so later writes never disturb a completed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
        end else begin
            r_vld1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat1 <= w_rd_dat;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             r_vld2;
            logic [WIDTH-1:0] r_dat2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld2 <= 1'b0;
                    r_dat2 <= '0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_dat2 <= r_dat1;
                    end
                end
            end

            assign dout     = r_dat2;
            assign dout_vld = r_vld2;
        end else begin : g_no_out_reg
            assign dout     = r_dat1;
            assign dout_vld = r_vld1;
        end
    endgenerate

    assign init_done = r_init_done;

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Two RAM instances share one stimulus stream: A (DEPTH 32, latency 1, bypass) and
// B (DEPTH 20, latency 2, no bypass); a scoreboard monitor checks every dout_vld pulse.
module tb_nv_ram_rws_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra, wa;
    logic        re, we;
    logic [15:0] di;
    logic [15:0] a_dout, b_dout;
    logic        a_vld, b_vld, a_done, b_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] dat;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    nv_ram_rws_param #(
        .WIDTH(16), .DEPTH(32), .AW(5), .OUT_REG(0), .BYPASS(1), .INIT_ZERO(1)
    ) dut_a (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .wa(wa), .we(we), .di(di),
        .dout(a_dout), .dout_vld(a_vld), .init_done(a_done), .pwrbus_ram_pd(32'h0)
    );

    nv_ram_rws_param #(
        .WIDTH(16), .DEPTH(20), .AW(5), .OUT_REG(1), .BYPASS(0), .INIT_ZERO(1)
    ) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .wa(wa), .we(we), .di(di),
        .dout(b_dout), .dout_vld(b_vld), .init_done(b_done), .pwrbus_ram_pd(32'h0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // One cycle of stimulus; a read pushes the hand-computed result for each instance.
    task automatic op(input logic w, input logic [4:0] a_w, input logic [15:0] d,
                      input logic r, input logic [4:0] a_r,
                      input logic [15:0] ea, input logic [15:0] eb);
        we = w; wa = a_w; di = d; re = r; ra = a_r;
        if (r) begin
            qa.push_back('{ea, cyc + 1});
            qb.push_back('{eb, cyc + 2});
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_vld) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_vld dout=%h cycle=%0d required=no pulse", a_dout, cyc);
            end else begin
                e = qa.pop_front();
                if (a_dout !== e.dat || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL a_read dout=%h cycle=%0d required dout=%h cycle=%0d",
                             a_dout, cyc, e.dat, e.cyc);
                end
            end
        end
        if (b_vld) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_vld dout=%h cycle=%0d required=no pulse", b_dout, cyc);
            end else begin
                e = qb.pop_front();
                if (b_dout !== e.dat || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL b_read dout=%h cycle=%0d required dout=%h cycle=%0d",
                             b_dout, cyc, e.dat, e.cyc);
                end
            end
        end
    end

    initial begin
        int t0;
        int ta;
        int tb;
        rst = 1'b1; re = 1'b0; we = 1'b0; ra = '0; wa = '0; di = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_dout", 32'(a_dout), 32'h0);
        chk("rst_b_dout", 32'(b_dout), 32'h0);
        chk("rst_a_vld",  32'(a_vld),  32'h0);
        chk("rst_a_done", 32'(a_done), 32'h0);
        chk("rst_b_done", 32'(b_done), 32'h0);

        // Start a sweep, then abort it after 10 edges with a 2-cycle reset.
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_a_done", 32'(a_done), 32'h0);
            chk("midrst_b_done", 32'(b_done), 32'h0);
            chk("midrst_vld", 32'({a_vld, b_vld}), 32'h0);
        end

        // Full sweep with a write and a read issued during INIT; both must be ignored.
        rst = 1'b0;
        t0 = cyc;
        ta = -1;
        tb = -1;
        we = 1'b1; wa = 5'd3; di = 16'hBEEF; re = 1'b1; ra = 5'd3;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                we = 1'b0;
                re = 1'b0;
            end
            if (ta < 0 && a_done) ta = cyc - t0;
            if (tb < 0 && b_done) tb = cyc - t0;
        end
        chk("init_a_cycles", 32'(ta), 32'd32);
        chk("init_b_cycles", 32'(tb), 32'd20);

        op(1'b0, 5'd0, 16'h0, 1'b1, 5'd3, 16'h0000, 16'h0000);

        op(1'b1, 5'd7, 16'h1234, 1'b0, 5'd0, 16'h0, 16'h0);
        op(1'b0, 5'd0, 16'h0, 1'b1, 5'd7, 16'h1234, 16'h1234);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_a_dout", 32'(a_dout), 32'h1234);
        chk("hold_b_dout", 32'(b_dout), 32'h1234);
        chk("hold_vld", 32'({a_vld, b_vld}), 32'h0);

        // Read-during-write on address 5.
        op(1'b1, 5'd5, 16'hAAAA, 1'b0, 5'd0, 16'h0, 16'h0);
        op(1'b1, 5'd5, 16'h5555, 1'b1, 5'd5, 16'h5555, 16'hAAAA);
        op(1'b0, 5'd0, 16'h0, 1'b1, 5'd5, 16'h5555, 16'h5555);

        for (int i = 0; i < 32; i++)
            op(1'b1, 5'(i), 16'(i * 3), 1'b0, 5'd0, 16'h0, 16'h0);
        for (int i = 0; i < 32; i++)
            op(1'b0, 5'd0, 16'h0, 1'b1, 5'(i), 16'(i * 3), (i < 20) ? 16'(i * 3) : 16'h0);

        // Address 25 is out of range for B only.
        op(1'b1, 5'd25, 16'hFFFF, 1'b0, 5'd0, 16'h0, 16'h0);
        op(1'b0, 5'd0, 16'h0, 1'b1, 5'd25, 16'hFFFF, 16'h0000);
        op(1'b0, 5'd0, 16'h0, 1'b1, 5'd19, 16'd57, 16'd57);
        for (int i = 0; i < 20; i++)
            op(1'b0, 5'd0, 16'h0, 1'b1, 5'(i), 16'(i * 3), 16'(i * 3));

        repeat (5) @(posedge clk);
        #1;
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_b", 32'(qb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
